// File: rtl/requant_relu_pipe.sv
// requant_relu_pipe
// Per-channel requantization stage: turns CHANNEL_OUT_NUM signed 32-bit
// convolution accumulators per beat into 8-bit unsigned features using
// per-channel bias/scale held in an internal parameter RAM.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   Start                pulse, begins parameter load for a new layer
//   Next_Reg             pulse, layer finished, return to IDLE
//   Channel_Out_Num_REG  output channels of the layer (groups = value >> 3)
//   Shift_REG            right shift applied after scaling (round half up)
//   Zero_Point_REG       output zero point
//   EN_Relu_REG          1: lower clamp = zero point, 0: lower clamp = 0
//   Param_Valid/Ready    parameter beat handshake (one beat per group)
//   Param_Data           lane i: bias [i*48 +: 32], scale [i*48+32 +: 16]
//   Acc_Valid/Acc_Data   accumulator beat, lane i at [i*32 +: 32], no backpressure
//   Feature_Out          lane i at [i*8 +: 8]
//   Valid_Out            Feature_Out valid, 4 cycles after the input beat
//   Param_Loaded         high while running
module requant_relu_pipe #(
  parameter int CHANNEL_OUT_NUM       = 8,
  parameter int WIDTH_CHANNEL_NUM_REG = 10,
  parameter int ACC_W                 = 32,
  parameter int SCALE_W               = 16,
  parameter int GROUP_ADDR_W          = 7
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        Start,
  input  logic                                        Next_Reg,
  input  logic [WIDTH_CHANNEL_NUM_REG-1:0]            Channel_Out_Num_REG,
  input  logic [4:0]                                  Shift_REG,
  input  logic [7:0]                                  Zero_Point_REG,
  input  logic                                        EN_Relu_REG,
  input  logic                                        Param_Valid,
  input  logic [CHANNEL_OUT_NUM*(ACC_W+SCALE_W)-1:0]  Param_Data,
  output logic                                        Param_Ready,
  input  logic                                        Acc_Valid,
  input  logic [CHANNEL_OUT_NUM*ACC_W-1:0]            Acc_Data,
  output logic [CHANNEL_OUT_NUM*8-1:0]                Feature_Out,
  output logic                                        Valid_Out,
  output logic                                        Param_Loaded
);

  localparam int PARAM_W   = ACC_W + SCALE_W;
  localparam int SUM_W     = ACC_W + 1;
  localparam int PROD_W    = SUM_W + SCALE_W;
  // One spare bit so the rounding add can never wrap.
  localparam int EXT_W     = PROD_W + 1;
  localparam int RAM_DEPTH = 1 << GROUP_ADDR_W;
  localparam logic [GROUP_ADDR_W-1:0] GRP_ONE = GROUP_ADDR_W'(1);
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'(255);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [GROUP_ADDR_W-1:0]         r_cnt_load;
  logic [GROUP_ADDR_W-1:0]         r_cnt_cin;
  logic [GROUP_ADDR_W-1:0]         w_channel_times;
  logic [GROUP_ADDR_W-1:0]         w_last_grp;
  logic                            w_load_fire;
  logic                            w_acc_fire;

  logic [CHANNEL_OUT_NUM*PARAM_W-1:0] r_param_ram [0:RAM_DEPTH-1];

  logic [CHANNEL_OUT_NUM*ACC_W-1:0]   r_acc_s0;
  logic [GROUP_ADDR_W-1:0]            r_addr_s0;
  logic [CHANNEL_OUT_NUM*ACC_W-1:0]   r_acc_e1;
  logic [CHANNEL_OUT_NUM*PARAM_W-1:0] r_param_e1;
  logic                               r_vld_s0, r_vld_e1, r_vld_e2, r_vld_e3;

  logic [CHANNEL_OUT_NUM*8-1:0]       w_feat_next;
  logic signed [EXT_W-1:0]            w_rnd;
  logic signed [EXT_W-1:0]            w_zp_ext;
  logic signed [EXT_W-1:0]            w_lo;

  assign w_channel_times = GROUP_ADDR_W'(Channel_Out_Num_REG >> 3);
  assign w_last_grp      = w_channel_times - GRP_ONE;
  assign w_load_fire     = (r_state == ST_LOAD) && Param_Valid;
  assign w_acc_fire      = (r_state == ST_RUN) && Acc_Valid;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    Param_Ready  = 1'b0;
    Param_Loaded = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start && (w_channel_times != '0)) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        Param_Ready = 1'b1;
        if (Next_Reg)                                  w_state_next = ST_IDLE;
        else if (Param_Valid && r_cnt_load == w_last_grp) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        Param_Loaded = 1'b1;
        if (Next_Reg) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Counters idle at zero outside their own state so every layer starts at group 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_load <= '0;
      r_cnt_cin  <= '0;
    end else begin
      if (r_state != ST_LOAD)
        r_cnt_load <= '0;
      else if (w_load_fire)
        r_cnt_load <= (r_cnt_load == w_last_grp) ? '0 : r_cnt_load + GRP_ONE;

      if (r_state != ST_RUN)
        r_cnt_cin <= '0;
      else if (w_acc_fire)
        r_cnt_cin <= (r_cnt_cin == w_last_grp) ? '0 : r_cnt_cin + GRP_ONE;
    end
  end

  // ---------------- parameter RAM ----------------
  always_ff @(posedge clk) begin
    if (w_load_fire) r_param_ram[r_cnt_load] <= Param_Data;
  end

  // Inputs are registered first so the RAM address comes from a flop; the
  // registered RAM read then lines up with the accumulator in E1.
  always_ff @(posedge clk) begin
    r_acc_s0   <= Acc_Data;
    r_addr_s0  <= r_cnt_cin;
    r_acc_e1   <= r_acc_s0;
    r_param_e1 <= r_param_ram[r_addr_s0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_s0  <= 1'b0;
      r_vld_e1  <= 1'b0;
      r_vld_e2  <= 1'b0;
      r_vld_e3  <= 1'b0;
      Valid_Out <= 1'b0;
    end else begin
      r_vld_s0  <= w_acc_fire;
      r_vld_e1  <= r_vld_s0;
      r_vld_e2  <= r_vld_e1;
      r_vld_e3  <= r_vld_e2;
      Valid_Out <= r_vld_e3;
    end
  end

  // Shared requantization terms (layer-static registers).
  assign w_rnd    = (Shift_REG == 5'd0) ? '0 : (EXT_W'(1) << (Shift_REG - 5'd1));
  assign w_zp_ext = $signed({{(EXT_W-8){1'b0}}, Zero_Point_REG});
  assign w_lo     = EN_Relu_REG ? w_zp_ext : '0;

  // ---------------- per-lane datapath ----------------
  generate
    for (genvar gi = 0; gi < CHANNEL_OUT_NUM; gi++) begin : g_lane
      logic signed [ACC_W-1:0]   w_acc;
      logic signed [ACC_W-1:0]   w_bias;
      logic signed [SCALE_W-1:0] w_scale;
      logic signed [SUM_W-1:0]   r_sum_e2;
      logic signed [SCALE_W-1:0] r_scale_e2;
      logic signed [PROD_W-1:0]  r_prod_e3;
      logic signed [EXT_W-1:0]   w_biased;
      logic signed [EXT_W-1:0]   w_shr;
      logic signed [EXT_W-1:0]   w_res;

      assign w_acc   = $signed(r_acc_e1[gi*ACC_W +: ACC_W]);
      assign w_bias  = $signed(r_param_e1[gi*PARAM_W +: ACC_W]);
      assign w_scale = $signed(r_param_e1[gi*PARAM_W+ACC_W +: SCALE_W]);

      always_ff @(posedge clk) begin
        r_sum_e2   <= SUM_W'(w_acc) + SUM_W'(w_bias);
        r_scale_e2 <= w_scale;
        r_prod_e3  <= PROD_W'(r_sum_e2) * PROD_W'(r_scale_e2);
      end

      assign w_biased = EXT_W'(r_prod_e3) + w_rnd;
      assign w_shr    = w_biased >>> Shift_REG;
      assign w_res    = w_shr + w_zp_ext;

      assign w_feat_next[gi*8 +: 8] = (w_res < w_lo)   ? w_lo[7:0] :
                                      (w_res > OUT_MAX) ? 8'hFF    : w_res[7:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)           Feature_Out <= '0;
    else if (r_vld_e3) Feature_Out <= w_feat_next;
  end

endmodule

// File: tb/tb_requant_relu_pipe.sv
// Testbench for requant_relu_pipe: scoreboard queue filled by the stimulus
// process from a behavioural model, drained by an independent monitor.
module tb_requant_relu_pipe;
  localparam int CH = 8;
  localparam int PW = CH * 48;

  logic            clk = 1'b0;
  logic            rst;
  logic            Start, Next_Reg;
  logic [9:0]      Channel_Out_Num_REG;
  logic [4:0]      Shift_REG;
  logic [7:0]      Zero_Point_REG;
  logic            EN_Relu_REG;
  logic            Param_Valid;
  logic [PW-1:0]   Param_Data;
  logic            Param_Ready;
  logic            Acc_Valid;
  logic [CH*32-1:0] Acc_Data;
  logic [CH*8-1:0] Feature_Out;
  logic            Valid_Out;
  logic            Param_Loaded;

  requant_relu_pipe dut (
    .clk(clk), .rst(rst), .Start(Start), .Next_Reg(Next_Reg),
    .Channel_Out_Num_REG(Channel_Out_Num_REG), .Shift_REG(Shift_REG),
    .Zero_Point_REG(Zero_Point_REG), .EN_Relu_REG(EN_Relu_REG),
    .Param_Valid(Param_Valid), .Param_Data(Param_Data), .Param_Ready(Param_Ready),
    .Acc_Valid(Acc_Valid), .Acc_Data(Acc_Data), .Feature_Out(Feature_Out),
    .Valid_Out(Valid_Out), .Param_Loaded(Param_Loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [63:0] feat; int due; } exp_t;
  exp_t sb_q[$];

  // Behavioural model state: parameters per group, group count, next group.
  int bias_m[128][CH];
  int scale_m[128][CH];
  int ct;
  int grp;
  int lanes[CH];

  function automatic logic [7:0] ref_lane(int acc, int bias, int scale, int sh, int zp, bit relu);
    longint s, p, r, lo;
    s = longint'(acc) + longint'(bias);
    p = s * longint'(scale);
    if (sh == 0) r = p;
    else         r = (p + (longint'(1) << (sh - 1))) >>> sh;  // floor((p + half) / 2^sh)
    r  = r + zp;
    lo = relu ? zp : 0;
    if (r < lo)  r = lo;
    if (r > 255) r = 255;
    return r[7:0];
  endfunction

  function automatic logic [255:0] pack_lanes();
    logic [255:0] v;
    for (int l = 0; l < CH; l++) v[l*32 +: 32] = lanes[l];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end else begin
      $display("[TB] check %s ok (%h)", name, act);
    end
  endtask

  // Monitor: compares every Valid_Out against the queue head, including its cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (Valid_Out === 1'b1) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got Valid_Out=1 at cycle %0d expected no output", cyc);
      end else begin
        e = sb_q.pop_front();
        if (Feature_Out !== e.feat || cyc != e.due) begin
          n_fail++;
          $display("FAIL beat: got %h at cycle %0d expected %h at cycle %0d",
                   Feature_Out, cyc, e.feat, e.due);
        end else begin
          $display("[TB] beat %h at cycle %0d", Feature_Out, cyc);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_beat: got Valid_Out=%b at cycle %0d expected %h", Valid_Out, cyc, e.feat);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_group(input int g, input int bias, input int scale);
    for (int l = 0; l < CH; l++) begin
      bias_m[g][l]  = bias;
      scale_m[g][l] = scale;
    end
  endtask

  // Beat accepted at the coming edge; output expected at the negedge after edge+4.
  task automatic send_beat(input logic [255:0] acc, input logic [63:0] exp_vec, input bit use_model);
    exp_t x;
    logic [63:0] e;
    e = exp_vec;
    if (use_model)
      for (int l = 0; l < CH; l++)
        e[l*8 +: 8] = ref_lane(acc[l*32 +: 32], bias_m[grp][l], scale_m[grp][l],
                               int'(Shift_REG), int'(Zero_Point_REG), EN_Relu_REG);
    Acc_Valid = 1'b1;
    Acc_Data  = acc;
    x.feat = e;
    x.due  = cyc + 5;
    sb_q.push_back(x);
    grp = (grp + 1) % ct;
    tick();
  endtask

  task automatic drop_beat();
    Acc_Valid = 1'b1;
    Acc_Data  = {8{$urandom}};
    tick();
    Acc_Valid = 1'b0;
  endtask

  task automatic idle(input int n);
    Acc_Valid = 1'b0;
    tick(n);
  endtask

  task automatic drain();
    int w = 0;
    Acc_Valid = 1'b0;
    while (sb_q.size() > 0 && w < 20) begin
      tick();
      w++;
    end
    check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic load_layer(input int chan, input bit inject_acc);
    int w;
    Channel_Out_Num_REG = chan[9:0];
    ct  = chan >> 3;
    grp = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int g = 0; g < ct; g++) begin
      if ($urandom_range(0, 3) == 0) begin
        Param_Valid = 1'b0;
        Acc_Valid   = inject_acc;
        tick();
      end
      for (int l = 0; l < CH; l++) begin
        Param_Data[l*48 +: 32]    = bias_m[g][l];
        Param_Data[l*48+32 +: 16] = scale_m[g][l][15:0];
      end
      Param_Valid = 1'b1;
      Acc_Valid   = inject_acc & ($urandom_range(0, 1) == 1);
      Acc_Data    = {8{$urandom}};
      w = 0;
      while (Param_Ready !== 1'b1 && w < 10) begin
        tick();
        w++;
      end
      if (w == 10) begin
        n_tests++;
        n_fail++;
        $display("FAIL param_ready_timeout: got Param_Ready=%b expected 1", Param_Ready);
      end
      tick();
    end
    Param_Valid = 1'b0;
    Acc_Valid   = 1'b0;
    check("loaded_flag", 64'(Param_Loaded), 64'd1);
    check("ready_low_in_run", 64'(Param_Ready), 64'd0);
  endtask

  task automatic next_layer();
    Next_Reg  = 1'b1;
    Acc_Valid = 1'b0;
    tick();
    Next_Reg = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v10, v220;
    rst = 1'b1; Start = 0; Next_Reg = 0; Channel_Out_Num_REG = '0;
    Shift_REG = '0; Zero_Point_REG = '0; EN_Relu_REG = 0;
    Param_Valid = 0; Param_Data = '0; Acc_Valid = 0; Acc_Data = '0;
    tick(3);
    check("rst_param_ready", 64'(Param_Ready), 64'd0);
    check("rst_valid_out", 64'(Valid_Out), 64'd0);
    check("rst_feature_out", Feature_Out, 64'd0);
    check("rst_param_loaded", 64'(Param_Loaded), 64'd0);
    rst = 1'b0;
    tick();

    // Start with zero groups is ignored.
    Channel_Out_Num_REG = 10'd7;
    Start = 1'b1; tick(); Start = 1'b0;
    check("start_ct0_ignored", 64'(Param_Ready), 64'd0);
    drop_beat();

    // Basic load and run, with accumulator pulses during LOAD that must be dropped.
    set_group(0, 0, 1);
    set_group(1, 100, 2);
    load_layer(16, 1'b1);
    for (int l = 0; l < CH; l++) lanes[l] = 10;
    v10  = {8{8'd10}};
    v220 = {8{8'd220}};
    for (int b = 0; b < 4; b++) send_beat(pack_lanes(), (b % 2) ? v220 : v10, 1'b0);
    // Gaps keep the group sequence 0,1,0,1.
    idle(2);
    send_beat(pack_lanes(), v10, 1'b0);
    idle(3);
    send_beat(pack_lanes(), v220, 1'b0);
    idle(1);
    send_beat(pack_lanes(), v10, 1'b0);
    send_beat(pack_lanes(), v220, 1'b0);
    // Next_Reg one cycle after the last beat; the following beat is dropped.
    next_layer();
    check("next_reg_idle", 64'(Param_Loaded), 64'd0);
    drop_beat();
    drain();

    // Rounding and clamp, single group.
    set_group(0, 0, 3);
    Shift_REG = 5'd2; Zero_Point_REG = 8'd0; EN_Relu_REG = 1'b0;
    load_layer(8, 1'b0);
    lanes = '{5, 1000, -20, -1, 7, 100000, -100000, 2};
    send_beat(pack_lanes(), '0, 1'b1);
    send_beat(pack_lanes(), '0, 1'b1);
    drain();
    next_layer();
    Zero_Point_REG = 8'd10; EN_Relu_REG = 1'b1;
    load_layer(8, 1'b0);
    send_beat(pack_lanes(), '0, 1'b1);
    drain();
    next_layer();

    // Negative rounding with scale 1, shift 2.
    set_group(0, 0, 1);
    Zero_Point_REG = 8'd0; EN_Relu_REG = 1'b0;
    load_layer(8, 1'b0);
    lanes = '{-6, -7, 6, 5, 2, -2, 1021, -1};
    send_beat(pack_lanes(), '0, 1'b1);
    idle(1);
    // Reset two cycles after a beat enters: that beat is lost.
    send_beat(pack_lanes(), '0, 1'b1);
    idle(1);
    drain_before_reset: begin
      // Only the beat just sent is outstanding once the earlier one has emitted.
      while (sb_q.size() > 1) tick();
    end
    rst = 1'b1;
    sb_q.delete();
    tick();
    rst = 1'b0;
    check("rst_mid_valid_out", 64'(Valid_Out), 64'd0);
    check("rst_mid_param_loaded", 64'(Param_Loaded), 64'd0);
    drop_beat();
    drop_beat();
    idle(6);

    // Randomized layers.
    for (int layer = 0; layer < 6; layer++) begin
      int chan;
      chan = (layer == 0) ? 8 : $urandom_range(8, 88);
      Shift_REG      = 5'($urandom_range(0, 31));
      Zero_Point_REG = 8'($urandom);
      EN_Relu_REG    = 1'($urandom);
      for (int g = 0; g < (chan >> 3); g++)
        for (int l = 0; l < CH; l++) begin
          bias_m[g][l]  = ($urandom_range(0, 3) == 0) ? int'($urandom) : (int'($urandom) >>> 12);
          scale_m[g][l] = int'($urandom) >>> 16;
        end
      load_layer(chan, 1'b1);
      for (int b = 0; b < 30; b++) begin
        for (int l = 0; l < CH; l++)
          lanes[l] = ($urandom_range(0, 1) == 1) ? int'($urandom) : (int'($urandom) >>> 18);
        if (b == 10) Start = 1'b1;
        send_beat(pack_lanes(), '0, 1'b1);
        if (b == 10) begin
          Start = 1'b0;
          check("start_in_run_ignored", {63'd0, Param_Loaded}, 64'd1);
        end
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      drain();
      // Next_Reg and Start together in RUN: Next_Reg wins.
      Next_Reg = 1'b1;
      Start    = 1'b1;
      tick();
      Next_Reg = 1'b0;
      Start    = 1'b0;
      check("next_wins_ready", 64'(Param_Ready), 64'd0);
      check("next_wins_loaded", 64'(Param_Loaded), 64'd0);
    end

    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
